// File: rtl/ssd_display_arbiter_if.sv
`default_nettype none
// ============================================================================
// ssd_display_arbiter_if : requester/display bus of the 7-seg display arbiter
// Rev 1.0
// ============================================================================
interface ssd_display_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    ssd_display_arbiter_port_req;
  logic [32*NUM_REQ-1:0] ssd_display_arbiter_port_data;
  logic                  ssd_display_arbiter_port_lock;
  logic [NUM_REQ-1:0]    ssd_display_arbiter_oport_grant;
  logic [31:0]           ssd_display_arbiter_oport_value;
  logic [OWN_W-1:0]      ssd_display_arbiter_oport_owner;
  logic                  ssd_display_arbiter_oport_switch;

  modport master (
    output ssd_display_arbiter_port_req,
    output ssd_display_arbiter_port_data,
    output ssd_display_arbiter_port_lock,
    input  ssd_display_arbiter_oport_grant,
    input  ssd_display_arbiter_oport_value,
    input  ssd_display_arbiter_oport_owner,
    input  ssd_display_arbiter_oport_switch
  );

  modport slave (
    input  ssd_display_arbiter_port_req,
    input  ssd_display_arbiter_port_data,
    input  ssd_display_arbiter_port_lock,
    output ssd_display_arbiter_oport_grant,
    output ssd_display_arbiter_oport_value,
    output ssd_display_arbiter_oport_owner,
    output ssd_display_arbiter_oport_switch
  );
endinterface
`default_nettype wire

// File: rtl/ssd_display_arbiter.sv
`default_nettype none
// ============================================================================
// ssd_display_arbiter : round-robin owner of the 7-seg display, minimum dwell
// Rev 1.0
// ============================================================================
module ssd_display_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          DWELL_CYCLES = 100_000_000,
  parameter logic [31:0] IDLE_VALUE   = 32'h0000_0000,
  parameter int          OWN_W        = $clog2(NUM_REQ)
) (
  input wire logic             ssd_display_arbiter_clk,
  input wire logic             ssd_display_arbiter_rst_n,
  ssd_display_arbiter_if.slave ssd_display_arbiter_bus
);
  localparam int               c_cnt_w    = $clog2(DWELL_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [OWN_W-1:0]     r_owner, w_owner_nxt;
  logic [OWN_W-1:0]     r_last, w_last_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [31:0]          r_value, w_value_nxt;
  logic                 r_switch, w_switch_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;

  logic [NUM_REQ-1:0]   w_req;
  logic                 w_any_req;
  logic                 w_found;
  logic [OWN_W-1:0]     w_idx;
  logic [OWN_W-1:0]     w_winner;
  logic [31:0]          w_owner_data;
  logic [31:0]          w_winner_data;
  logic                 w_take;

  // Search last+1 .. last+NUM_REQ; the final step wraps back onto last itself.
  always_comb begin
    w_req     = ssd_display_arbiter_bus.ssd_display_arbiter_port_req;
    w_any_req = |w_req;
    w_found   = 1'b0;
    w_idx     = r_last;
    w_winner  = r_last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = r_last + OWN_W'(i);
      if (!w_found && w_req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_owner_data  = '0;
    w_winner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == OWN_W'(i))
        w_owner_data = ssd_display_arbiter_bus.ssd_display_arbiter_port_data[32*i +: 32];
      if (w_winner == OWN_W'(i))
        w_winner_data = ssd_display_arbiter_bus.ssd_display_arbiter_port_data[32*i +: 32];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_grant_nxt  = r_grant;
    w_value_nxt  = r_value;
    w_cnt_nxt    = r_cnt;
    w_switch_nxt = 1'b0;
    w_take       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        w_value_nxt = IDLE_VALUE;
        if (w_any_req)
          w_take = 1'b1;
      end
      ST_GRANT: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
        w_value_nxt = w_owner_data;
      end
      ST_HOLD: begin
        w_value_nxt = w_owner_data;
        // An owner dropping its request overrides both expiry and lock.
        if (!w_req[r_owner]) begin
          if (w_any_req) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_value_nxt = IDLE_VALUE;
          end
        end else if (!ssd_display_arbiter_bus.ssd_display_arbiter_port_lock) begin
          if (r_cnt == c_cnt_last) begin
            if (w_winner != r_owner)
              w_take = 1'b1;
            else
              w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_value_nxt = IDLE_VALUE;
      end
    endcase

    if (w_take) begin
      w_state_nxt  = ST_GRANT;
      w_owner_nxt  = w_winner;
      w_last_nxt   = w_winner;
      w_grant_nxt  = NUM_REQ'(1) << w_winner;
      w_value_nxt  = w_winner_data;
      w_switch_nxt = 1'b1;
    end
  end

  always_ff @(posedge ssd_display_arbiter_clk or negedge ssd_display_arbiter_rst_n) begin
    if (!ssd_display_arbiter_rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_last   <= OWN_W'(NUM_REQ - 1);
      r_grant  <= '0;
      r_value  <= IDLE_VALUE;
      r_switch <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_grant  <= w_grant_nxt;
      r_value  <= w_value_nxt;
      r_switch <= w_switch_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign ssd_display_arbiter_bus.ssd_display_arbiter_oport_grant  = r_grant;
  assign ssd_display_arbiter_bus.ssd_display_arbiter_oport_value  = r_value;
  assign ssd_display_arbiter_bus.ssd_display_arbiter_oport_owner  = r_owner;
  assign ssd_display_arbiter_bus.ssd_display_arbiter_oport_switch = r_switch;
endmodule
`default_nettype wire

// File: tb/tb_ssd_display_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ssd_display_arbiter : directed scoreboard bench for ssd_display_arbiter
// Rev 1.0
// ============================================================================
module tb_ssd_display_arbiter;
  localparam int          NUM_REQ = 4;
  localparam int          DWELL   = 8;
  localparam logic [31:0] IDLE_V  = 32'hDEAD_0000;
  localparam logic [31:0] D0 = 32'hA000_0000;
  localparam logic [31:0] D1 = 32'hB111_1111;
  localparam logic [31:0] D3 = 32'hD333_3333;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] data;
  logic                  lock;
  logic [NUM_REQ-1:0]    grant;
  logic [31:0]           value;
  logic [1:0]            owner;
  logic                  sw;

  ssd_display_arbiter_if #(.NUM_REQ(NUM_REQ)) u_bus ();

  assign u_bus.ssd_display_arbiter_port_req  = req;
  assign u_bus.ssd_display_arbiter_port_data = data;
  assign u_bus.ssd_display_arbiter_port_lock = lock;
  assign grant = u_bus.ssd_display_arbiter_oport_grant;
  assign value = u_bus.ssd_display_arbiter_oport_value;
  assign owner = u_bus.ssd_display_arbiter_oport_owner;
  assign sw    = u_bus.ssd_display_arbiter_oport_switch;

  ssd_display_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DWELL_CYCLES (DWELL),
    .IDLE_VALUE   (IDLE_V)
  ) u_dut (
    .ssd_display_arbiter_clk   (clk),
    .ssd_display_arbiter_rst_n (rst_n),
    .ssd_display_arbiter_bus   (u_bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  owner;
    logic [3:0]  grant;
    logic [31:0] value;
  } grant_t;

  typedef struct {
    int          cyc;
    logic [31:0] value;
    logic [3:0]  grant;
  } val_t;

  grant_t gnt_q[$];
  val_t   val_q[$];
  grant_t ge;
  val_t   ve;
  logic   prev_sw = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    data[32*i +: 32] = v;
  endtask

  task automatic exp_grant(input int c, input int own, input logic [31:0] v);
    grant_t e;
    e.cyc   = c;
    e.owner = 2'(own);
    e.grant = 4'b0001 << own;
    e.value = v;
    gnt_q.push_back(e);
  endtask

  task automatic exp_val(input int c, input logic [31:0] v, input logic [3:0] g);
    val_t e;
    e.cyc   = c;
    e.value = v;
    e.grant = g;
    val_q.push_back(e);
  endtask

  // Monitor: every new grant must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sw = 1'b0;
    end else begin
      if (val_q.size() > 0 && val_q[0].cyc <= cyc) begin
        ve = val_q.pop_front();
        chk("val_cycle", cyc, ve.cyc);
        chk("value", value, ve.value);
        chk("grant_with_value", {28'd0, grant}, {28'd0, ve.grant});
      end
      if (sw) begin
        if (gnt_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_switch @cycle %0d: got switch=1 owner=%0d, expected switch=0", cyc, owner);
        end else begin
          ge = gnt_q.pop_front();
          chk("switch_cycle", cyc, ge.cyc);
          chk("grant_owner", {30'd0, owner}, {30'd0, ge.owner});
          chk("grant_onehot", {28'd0, grant}, {28'd0, ge.grant});
          chk("grant_value", value, ge.value);
        end
        chk("switch_not_back_to_back", {31'd0, prev_sw}, 32'd0);
      end
      prev_sw = sw;
    end
  end

  int k, a, b, c;

  initial begin
    req  = '0;
    lock = 1'b0;
    data = '0;
    set_data(0, D0);
    set_data(1, D1);
    set_data(3, D3);

    step(3);
    chk("rst_value", value, IDLE_V);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_switch", {31'd0, sw}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);

    // Rotation from reset pointer: 0, 1, 3, 0, nine cycles each.
    rst_n = 1'b1;
    req   = 4'b1011;
    k     = cyc;
    exp_grant(k + 1,  0, D0);
    exp_grant(k + 10, 1, D1);
    exp_grant(k + 19, 3, D3);
    exp_grant(k + 28, 0, D0);
    step(30);
    req = 4'b0000;
    exp_val(cyc + 1, IDLE_V, 4'b0000);
    step(2);
    chk("idle_owner_kept_0", {30'd0, owner}, 32'd0);

    // Single requester: no further switch pulses over 40 cycles.
    set_data(2, 32'h1234_5678);
    req = 4'b0100;
    exp_grant(cyc + 1, 2, 32'h1234_5678);
    step(41);
    chk("single_grant_held", {28'd0, grant}, 32'h4);
    chk("single_value_held", value, 32'h1234_5678);
    req = 4'b0000;
    exp_val(cyc + 1, IDLE_V, 4'b0000);
    step(2);
    chk("idle_owner_kept_2", {30'd0, owner}, 32'd2);

    // Owner drop at counter 3.
    a   = cyc;
    req = 4'b0010;
    exp_grant(a + 1, 1, D1);
    step(2);
    req = 4'b0011;
    step(3);
    req = 4'b0001;
    exp_grant(a + 6, 0, D0);
    step(1);
    req = 4'b0000;
    exp_val(a + 7, D0, 4'b0001);
    exp_val(a + 8, IDLE_V, 4'b0000);
    step(3);

    // Lock freezes the count at 2 for 50 cycles; release resumes from there.
    b   = cyc;
    req = 4'b0001;
    exp_grant(b + 1, 0, D0);
    step(4);
    req  = 4'b0011;
    lock = 1'b1;
    step(50);
    lock = 1'b0;
    exp_grant(b + 60, 1, D1);
    exp_grant(b + 69, 0, D0);
    step(17);
    lock = 1'b1;
    req  = 4'b0010;
    exp_grant(b + 72, 1, D1);
    step(1);
    req  = 4'b0000;
    lock = 1'b0;
    exp_val(b + 74, IDLE_V, 4'b0000);
    step(3);

    // Live data on owner 2 with 1-cycle latency, locked for the second half.
    c = cyc;
    set_data(2, 32'hC0DE_0000);
    req = 4'b0100;
    exp_grant(c + 1, 2, 32'hC0DE_0000);
    for (int t = 1; t <= 20; t++) begin
      step(1);
      if (t == 10) lock = 1'b1;
      set_data(2, 32'hC0DE_0000 + 32'(t));
      exp_val(cyc + 1, 32'hC0DE_0000 + 32'(t), 4'b0100);
    end

    // Asynchronous reset in the middle of HOLD.
    step(1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_rst_value", value, IDLE_V);
    chk("async_rst_grant", {28'd0, grant}, 32'd0);
    chk("async_rst_switch", {31'd0, sw}, 32'd0);
    chk("async_rst_owner", {30'd0, owner}, 32'd0);
    lock = 1'b0;
    req  = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_grant", {28'd0, grant}, 32'd0);
    chk("grant_queue_drained", 32'(gnt_q.size()), 32'd0);
    chk("value_queue_drained", 32'(val_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ssd_display_arbiter.md
Name: ssd_display_arbiter

Overview:
- Shares the 8-digit seven-segment display between NUM_REQ requesters, e.g. FIFO data, FIFO status/count and switch echo.
- Each requester presents a 32-bit hex value plus a request. The arbiter grants one owner at a time, round-robin, with a minimum dwell time.
- It drives the 32-bit input of the display manager with the owner's value.
- When no one requests, it drives a fixed idle pattern.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- DWELL_CYCLES, 100_000_000, cycles an owner is held before rotation (1 s at 100 MHz); must be >= 2.
- IDLE_VALUE, 32'h0000_0000, value shown when no owner.
- OWN_W, $clog2(NUM_REQ), owner index width (derived).

Ports:
- ssd_display_arbiter_clk, in, 1, system clock; all logic on rising edge.
- ssd_display_arbiter_rst_n, in, 1, reset; asynchronous, active-low.
- ssd_display_arbiter_port_req, in, NUM_REQ, bit i = requester i wants the display.
- ssd_display_arbiter_port_data, in, 32*NUM_REQ, requester i value at [32i+31:32i].
- ssd_display_arbiter_port_lock, in, 1, 1 = freeze rotation on current owner.
- ssd_display_arbiter_oport_grant, out, NUM_REQ, one-hot grant; all zero when idle.
- ssd_display_arbiter_oport_value, out, 32, value to display manager input.
- ssd_display_arbiter_oport_owner, out, OWN_W, current/last owner index.
- ssd_display_arbiter_oport_switch, out, 1, one-cycle pulse on every new grant.

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - state = IDLE, grant = 0, value = IDLE_VALUE, owner = 0, switch = 0.
  - Dwell counter = 0.
  - Round-robin pointer last = NUM_REQ-1, so the first search starts at index 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Round-robin search: indices last+1, last+2, ... wrapping mod NUM_REQ, with last itself checked final. The first index with req=1 wins.
- IDLE:
  - grant = 0, value = IDLE_VALUE.
  - If any req bit = 1 at edge k: after edge k state = GRANT, owner/grant = winner, last = winner, switch = 1, value = winner's data sampled at edge k.
- GRANT (exactly 1 cycle):
  - Unconditionally goes to HOLD. Counter cleared to 0, switch back to 0.
  - value reloads owner data each edge.
- HOLD:
  - value = owner's data, re-sampled every edge (1-cycle latency from data port to value).
  - Counter increments each cycle.
  - Owner request drop (req[owner] = 0) wins over expiry and lock. Re-arbitrate at once: if any other req, go to GRANT with the next owner; else go to IDLE with grant = 0, value = IDLE_VALUE, and owner keeping the last index.
  - Expiry: counter == DWELL_CYCLES-1 and lock = 0. If another req is set, go to GRANT with the round-robin winner. If only the owner requests, clear the counter and stay in HOLD with no switch pulse.
  - lock = 1: counter holds at its value and never expires. Releasing lock resumes counting from the held value.
- Dwell time on rotation: owner holds the display for DWELL_CYCLES+1 cycles, including the GRANT cycle.
- grant always equals the one-hot of owner outside IDLE. switch never pulses on two consecutive cycles.
- Data changes during HOLD appear on value one edge later and are never blocked by lock.

Test Plan (bench uses DWELL_CYCLES = 8, NUM_REQ = 4, IDLE_VALUE = 32'hDEAD_0000):
- Reset: hold rst_n = 0 → value = 32'hDEAD_0000, grant = 4'b0000, switch = 0. Assert rst_n = 0 mid-HOLD → outputs return to these values before the next edge.
- Single requester: req = 4'b0100 with data2 = 32'h1234_5678 → one edge later grant = 4'b0100, owner = 2, switch = 1 for 1 cycle, value = 32'h1234_5678. Grant stays, with no further switch pulses, for 40 cycles.
- Rotation: req = 4'b1011 held → owners 0, 1, 3, 0 in order, each granted for exactly 9 cycles, with switch pulsing once per change.
- Owner drop: owner 1 in HOLD at counter 3, req goes from 4'b0011 to 4'b0001 → next edge GRANT owner 0. Then req = 0 → IDLE, value = 32'hDEAD_0000, grant = 0.
- Lock: owner 0, req = 4'b0011, lock = 1 for 50 cycles → no rotation. Release lock → owner 1 granted at the expected remaining count. Lock = 1 while owner 0 drops its req → owner 1 granted next edge anyway.
- Live data: change data of current owner every cycle → value tracks with exactly 1 cycle latency, including during lock.
